// File: rtl/mvm_feeder_if.sv
// rtl/mvm_feeder_if.sv - command, element stream and engine-side signals of the mvm feeder
//
// Purpose: bundles the handshake buses around mvm_feeder.
//   master : the environment side. It drives commands, stream elements and engine done,
//            and receives the ready signals and the engine pulses and data.
//   slave  : the feeder side, with the directions reversed.
// Signals:
//   cmd_valid/cmd_op/cmd_ready  command channel (op 00 load matrix, 01 load vector, 10 start)
//   s_valid/s_data/s_ready      element stream, row-major for the matrix
//   mvm_loadMatrix/mvm_loadVector/mvm_start  one-cycle pulses to the engine
//   mvm_data_in                 element burst to the engine
//   mvm_done                    engine completion pulse
interface mvm_feeder_if #(
  parameter int B = 8
);
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic         cmd_ready;
  logic         s_valid;
  logic [B-1:0] s_data;
  logic         s_ready;
  logic         mvm_loadMatrix;
  logic         mvm_loadVector;
  logic         mvm_start;
  logic [B-1:0] mvm_data_in;
  logic         mvm_done;

  modport master (
    output cmd_valid, cmd_op, s_valid, s_data, mvm_done,
    input  cmd_ready, s_ready, mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in
  );

  modport slave (
    input  cmd_valid, cmd_op, s_valid, s_data, mvm_done,
    output cmd_ready, s_ready, mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in
  );
endinterface

// File: rtl/mvm_feeder.sv
// rtl/mvm_feeder.sv - stages matrix/vector operands and sequences the mvm engine
//
// Purpose: accepts elements on a valid/ready stream into a K*K register buffer.
//   The operand is replayed to the engine as a gapless burst behind a single load
//   pulse. Start is issued as one pulse, after which the feeder waits for done plus
//   DRAIN cycles, so the engine never sees overlapping operations.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   bus     mvm_feeder_if.slave: command, element stream, and engine pulses/data/done
//   busy    high in every state except IDLE
//   err_op  sticky flag, set when reserved op 11 is accepted
module mvm_feeder #(
  parameter int K     = 8,
  parameter int B     = 8,
  parameter int DRAIN = K + 2
) (
  input  logic         clk,
  input  logic         reset,
  mvm_feeder_if.slave  bus,
  output logic         busy,
  output logic         err_op
);

  localparam int NMAT = K * K;
  localparam int AW   = $clog2(NMAT);
  // One counter serves fill, burst and drain, so it must hold the larger of the two ranges.
  localparam int CW   = $clog2(((NMAT > DRAIN) ? NMAT : DRAIN) + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PULSE,
    S_BURST,
    S_GUARD,
    S_START,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  n_q, n_d;
  logic           is_vec_q, is_vec_d;
  logic           err_op_q, err_op_d;
  logic [B-1:0]   buf_q [NMAT];
  logic [B-1:0]   buf_d [NMAT];

  logic [AW-1:0]  idx;
  logic           cmd_fire;
  logic           s_fire;

  assign idx      = cnt_q[AW-1:0];
  assign cmd_fire = bus.cmd_valid && (state_q == S_IDLE);
  assign s_fire   = bus.s_valid && (state_q == S_FILL);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      is_vec_q <= 1'b0;
      err_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      is_vec_q <= is_vec_d;
      err_op_q <= err_op_d;
    end
  end

  // Operand storage: contents are don't-care after reset, so the buffer has no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    buf_d = buf_q;
    if (s_fire) begin
      buf_d[idx] = bus.s_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    is_vec_d = is_vec_q;
    err_op_d = err_op_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          unique case (bus.cmd_op)
            2'b00: begin
              state_d  = S_FILL;
              n_d      = CW'(NMAT);
              is_vec_d = 1'b0;
              cnt_d    = '0;
            end
            2'b01: begin
              state_d  = S_FILL;
              n_d      = CW'(K);
              is_vec_d = 1'b1;
              cnt_d    = '0;
            end
            2'b10:   state_d  = S_START;
            default: err_op_d = 1'b1;
          endcase
        end
      end
      S_FILL: begin
        if (s_fire) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == n_q - CW'(1)) begin
            state_d = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        cnt_d   = '0;
        state_d = S_BURST;
      end
      S_BURST: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == n_q - CW'(1)) begin
          state_d = S_GUARD;
        end
      end
      S_GUARD: state_d = S_IDLE;
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (bus.mvm_done) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DRAIN - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on state, so asserting reset clears them immediately.
  // cmd_ready is additionally gated by reset so that it stays low while reset is held.
  always_comb begin
    bus.cmd_ready      = (state_q == S_IDLE) && reset;
    bus.s_ready        = (state_q == S_FILL);
    bus.mvm_loadMatrix = (state_q == S_PULSE) && !is_vec_q;
    bus.mvm_loadVector = (state_q == S_PULSE) && is_vec_q;
    bus.mvm_start      = (state_q == S_START);
    bus.mvm_data_in    = (state_q == S_BURST) ? buf_q[idx] : '0;
    busy               = (state_q != S_IDLE);
    err_op             = err_op_q;
  end

endmodule

// File: tb/tb_mvm_feeder.sv
// tb/tb_mvm_feeder.sv - directed self-checking bench for mvm_feeder
module tb_mvm_feeder;

  logic clk;
  logic reset;
  logic busy;
  logic err_op;
  int   checks;
  int   failures;
  logic [7:0] vals [64];

  mvm_feeder_if #(.B(8)) bus ();

  mvm_feeder #(.K(8), .B(8), .DRAIN(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busy   (busy),
    .err_op (err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulses_chk(input string tag, input logic lm, input logic lv, input logic st);
    chk({tag, "_loadMatrix"}, 32'(bus.mvm_loadMatrix), 32'(lm));
    chk({tag, "_loadVector"}, 32'(bus.mvm_loadVector), 32'(lv));
    chk({tag, "_start"}, 32'(bus.mvm_start), 32'(st));
  endtask

  // Presents a command and waits, with a bound, for it to be accepted.
  task automatic send_cmd(input logic [1:0] op);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    while (!bus.cmd_ready && n < 300) begin
      step();
      n++;
    end
    chk("cmd_accept_timeout", 32'(n < 300), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Streams vals[0..n-1], optionally with an idle cycle before each element.
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bus.s_valid = 1'b0;
        chk("fill_s_ready_gap", 32'(bus.s_ready), 32'd1);
        step();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = vals[i];
      chk("fill_s_ready", 32'(bus.s_ready), 32'd1);
      step();
    end
    bus.s_valid = 1'b0;
  endtask

  // Called in the pulse cycle: checks the pulse, the gapless burst, the guard cycle and the return to IDLE.
  task automatic check_load(input bit is_vec, input int n);
    pulses_chk("pulse", !is_vec, is_vec, 1'b0);
    chk("pulse_s_ready", 32'(bus.s_ready), 32'd0);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("burst_%0d", i), 32'(bus.mvm_data_in), 32'(vals[i]));
      pulses_chk("burst", 1'b0, 1'b0, 1'b0);
    end
    step();
    chk("guard_busy", 32'(busy), 32'd1);
    chk("guard_data", 32'(bus.mvm_data_in), 32'd0);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.mvm_done  = 1'b0;

    // Reset state
    step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_op", 32'(err_op), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    pulses_chk("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Matrix load 1..64, no gaps
    for (int i = 0; i < 64; i++) vals[i] = 8'(i + 1);
    send_cmd(2'b00);
    chk("fill_busy", 32'(busy), 32'd1);
    chk("fill_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    feed(64, 1'b0);
    check_load(1'b0, 64);

    // Vector load -1..-8 with s_valid toggling
    for (int i = 0; i < 8; i++) vals[i] = 8'(-(i + 1));
    send_cmd(2'b01);
    feed(8, 1'b1);
    check_load(1'b1, 8);

    // mvm_done outside RUN is ignored
    bus.mvm_done = 1'b1;
    step();
    bus.mvm_done = 1'b0;
    chk("done_idle_busy", 32'(busy), 32'd0);

    // Start, done after 20 cycles, then 10 drain cycles
    send_cmd(2'b10);
    pulses_chk("start", 1'b0, 1'b0, 1'b1);
    step();
    pulses_chk("run", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("run_busy", 32'(busy), 32'd1);
    bus.mvm_done = 1'b1;
    step();
    bus.mvm_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("drain_busy_%0d", i), 32'(busy), 32'd1);
      chk("drain_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      step();
    end
    chk("drain_end_busy", 32'(busy), 32'd0);
    chk("drain_end_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Command held through an entire load; the second one is taken on the first IDLE cycle
    for (int i = 0; i < 8; i++) vals[i] = 8'(16 * i + 3);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("held_cmd_ready_fill", 32'(bus.cmd_ready), 32'd0);
      bus.s_valid = 1'b1;
      bus.s_data  = vals[i];
      step();
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("held_cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
      step();
    end
    chk("held_first_idle", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    chk("held_second_accepted", 32'(bus.s_ready), 32'd1);
    feed(8, 1'b0);
    check_load(1'b1, 8);

    // Reset asserted at burst element 30
    for (int i = 0; i < 64; i++) vals[i] = 8'(3 * i + 7);
    send_cmd(2'b00);
    feed(64, 1'b0);
    chk("mid_pulse", 32'(bus.mvm_loadMatrix), 32'd1);
    for (int i = 0; i < 31; i++) step();
    chk("mid_elem30", 32'(bus.mvm_data_in), 32'(vals[30]));
    reset = 1'b0;
    #1;
    chk("mid_rst_data", 32'(bus.mvm_data_in), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    pulses_chk("mid_rst", 1'b0, 1'b0, 1'b0);
    step();
    chk("mid_rst_held_data", 32'(bus.mvm_data_in), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 64; i++) vals[i] = 8'(255 - i);
    send_cmd(2'b00);
    feed(64, 1'b0);
    check_load(1'b0, 64);

    // Reserved op: sticky error, no pulses, then a normal vector load
    send_cmd(2'b11);
    chk("err_op_set", 32'(err_op), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    pulses_chk("err", 1'b0, 1'b0, 1'b0);
    step();
    pulses_chk("err_next", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) vals[i] = 8'(i + 1);
    send_cmd(2'b01);
    feed(8, 1'b0);
    check_load(1'b1, 8);
    chk("err_op_sticky", 32'(err_op), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvm_feeder.md
Name: mvm_feeder

Overview:
- Upstream command/stream front-end for the mvm_<k>_<p>_<b>_<g> engine.
- Accepts matrix and vector elements on a valid/ready stream and stages a full operand in an internal buffer.
- Replays the operand to the engine as a gapless one-element-per-cycle burst behind a single loadMatrix/loadVector pulse.
- Sequences start and waits for done plus the result read-out window, so the engine never sees overlapping operations.

Parameters:
- K, 8, matrix dimension; the matrix is K×K and the vector is K.
- B, 8, element width in bits.
- DRAIN, K+2, cycles held busy after mvm_done so the engine finishes emitting y.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  00 = load matrix, 01 = load vector, 10 = start, 11 = reserved.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- s_valid  in  1  element present.
- s_data  in  B  signed element, row-major for the matrix.
- s_ready  out  1  element accepted when s_valid && s_ready.
- mvm_loadMatrix  out  1  one-cycle load pulse to the engine.
- mvm_loadVector  out  1  one-cycle load pulse to the engine.
- mvm_start  out  1  one-cycle start pulse.
- mvm_data_in  out  B  element burst to the engine.
- mvm_done  in  1  engine completion pulse.
- busy  out  1  high in every state except IDLE.
- err_op  out  1  sticky; set when op 11 is accepted.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; all outputs 0, except cmd_ready=1 once reset is released.
  - Counters are cleared; buffer contents are don't-care.
  - Reset asserted mid-operation aborts immediately. No further pulses are issued, and a partial burst is simply truncated.
- Storage: K*K×B register buffer plus an element counter of width clog2(K*K+1). N = K*K for a matrix, K for a vector.
- IDLE:
  - cmd_ready=1; s_ready=0.
  - On command handshake: op 00/01 → FILL with N latched and cnt=0; op 10 → START; op 11 → set err_op and stay in IDLE.
- FILL:
  - s_ready=1 and cmd_ready=0.
  - Each s handshake writes buf[cnt] and increments cnt.
  - When the handshake with cnt=N-1 occurs → PULSE on the next edge.
  - s_valid gaps are allowed and simply stall filling.
- PULSE: for one cycle, assert mvm_loadMatrix (op 00) or mvm_loadVector (op 01); cnt=0 → BURST.
- BURST:
  - Exactly N consecutive cycles, with mvm_data_in=buf[cnt] and cnt incremented each cycle.
  - Element 0 appears in the cycle immediately after the pulse cycle; no bubbles are permitted.
  - After element N-1 → GUARD.
  - mvm_data_in = 0 outside BURST.
- GUARD: one idle cycle so the engine returns to its ready state → IDLE.
- START: assert mvm_start for one cycle → RUN.
- RUN: wait for mvm_done=1 → DRAIN with cnt=0. The wait is unbounded.
- DRAIN: count DRAIN cycles, then → IDLE.
- mvm_done outside RUN is ignored.
- Pulse exclusivity: at most one of the three mvm_* pulse outputs is high in any cycle, and each is high for exactly one cycle per command.
- Throughput: a load occupies 1 + N (fill, at best) + 1 + N + 1 cycles; no data-path arithmetic, pure buffering.
- Command ordering is the user's responsibility. Start before any load is legal, and the engine computes on stale memory.

Test Plan:
- Matrix load, K=8: ops 00, then s_data 1..64 with no gaps → one mvm_loadMatrix pulse at cycle T; mvm_data_in = 1,2,…,64 on T+1…T+64; busy falls at T+66.
- Vector load with s_valid toggling every other cycle, data −1..−8 → s_ready high only in FILL; burst is −1..−8, contiguous, 8 cycles.
- Start: op 10 → mvm_start single pulse. Drive mvm_done 20 cycles later → busy stays high 10 more cycles (DRAIN=10), then cmd_ready=1.
- Commands during busy: cmd_valid held through an entire load → cmd_ready=0 until IDLE; second command accepted on the first IDLE cycle.
- Reset mid-burst: reset=0 at burst element 30 → all mvm_* outputs 0 asynchronously, busy=0; after release a fresh 64-element load bursts correctly.
- Op 11 → err_op=1 and stays set, no mvm_* pulses; a subsequent op 01 works normally.
- Full flow against the mvm engine: A = identity, x = 1..8 → engine outputs y = 1..8.
